// File: rtl/modem_pkg.sv
// Shared modem types: sample format, ADC width and ingest FSM encoding.
package modem_pkg;

  localparam int ADC_W = 8;

  typedef logic signed [ADC_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } ingest_state_t;

  // Offset-binary to two's complement: flipping the MSB re-centres 0x80 to zero.
  function automatic sample_t ob_to_tc(input logic [ADC_W-1:0] d);
    return {~d[ADC_W-1], d[ADC_W-2:0]};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word fall-through FIFO with registered head, occupancy and synchronous flush.
module sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // Head register; the next head is the incoming word only when it lands in the read slot.
      if (count_d != '0)
        dout_q <= (do_push && (rd_ptr_d == wr_ptr_q)) ? din_i : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = dout_q;
  assign level_o = count_q;

endmodule

// File: rtl/adc_sample_ingest.sv
// ADC sample ingest: AdcClk edge detect, arming FSM, offset-binary conversion, FIFO and drop accounting.
// Build option DC_REMOVE_EN adds an IIR DC-removal stage ahead of the FIFO.
module adc_sample_ingest
  import modem_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DC_SHIFT   = 6,
  parameter int DROP_CNT_W = 16
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          Enable,
  input  logic                          Flush,
  input  logic                          AdcClk,
  input  logic [ADC_W-1:0]              AdcData,
  output logic [ADC_W-1:0]              SampleOut,
  output logic                          SampleValid,
  input  logic                          SampleReady,
  output logic                          Overflow,
  output logic [DROP_CNT_W-1:0]         DropCnt,
  output logic [$clog2(FIFO_DEPTH):0]   Level,
  output logic [1:0]                    DbgState
);

  // Handshake: a sample transfers on a Clk edge where SampleValid & SampleReady;
  // SampleValid never depends on SampleReady and SampleOut is stable while valid.

  ingest_state_t      state_q;
  logic               adc_clk_q;
  logic               fall, rise;
  logic               cap_vld_q, cap_vld_d;
  sample_t            cap_q;
  logic               push, pop, drop, fifo_full, fifo_empty;
  logic [ADC_W-1:0]   push_data;
  logic               overflow_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  assign fall      = adc_clk_q & ~AdcClk;
  assign rise      = ~adc_clk_q & AdcClk;
  assign cap_vld_d = fall & Enable & (state_q == RUN);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      adc_clk_q <= 1'b1;
      state_q   <= IDLE;
    end else begin
      adc_clk_q <= AdcClk;
      if (!Enable) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE:    state_q <= ARM;
          ARM:     if (rise) state_q <= RUN;
          RUN:     state_q <= RUN;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cap_vld_q <= 1'b0;
      cap_q     <= '0;
    end else begin
      cap_vld_q <= cap_vld_d & ~Flush;
      if (cap_vld_d) cap_q <= ob_to_tc(AdcData);
    end
  end

`ifdef DC_REMOVE_EN
  localparam int ACC_W = ADC_W + DC_SHIFT;

  logic signed [ACC_W-1:0] acc_q, dc_est;
  logic signed [ACC_W:0]   err;
  sample_t                 err_sat, dc_q;
  logic                    dc_vld_q;

  always_comb begin
    dc_est = acc_q >>> DC_SHIFT;
    err    = $signed({{(DC_SHIFT+1){cap_q[ADC_W-1]}}, cap_q})
           - $signed({dc_est[ACC_W-1], dc_est});
    if (err > 127)       err_sat = 8'sd127;
    else if (err < -128) err_sat = -8'sd128;
    else                 err_sat = err[ADC_W-1:0];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc_q    <= '0;
      dc_q     <= '0;
      dc_vld_q <= 1'b0;
    end else if (Flush) begin
      acc_q    <= '0;
      dc_vld_q <= 1'b0;
    end else begin
      dc_vld_q <= cap_vld_q;
      if (cap_vld_q) begin
        acc_q <= acc_q + err[ACC_W-1:0];
        dc_q  <= err_sat;
      end
    end
  end

  assign push      = dc_vld_q;
  assign push_data = dc_q;
`else
  logic unused_dc_shift;
  assign unused_dc_shift = ^DC_SHIFT;
  assign push      = cap_vld_q;
  assign push_data = cap_q;
`endif

  assign pop  = ~fifo_empty & SampleReady;
  assign drop = push & fifo_full & ~pop;

  sample_fifo #(
    .WIDTH (ADC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .flush_i (Flush),
    .push_i  (push),
    .din_i   (push_data),
    .pop_i   (pop),
    .dout_o  (SampleOut),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (Level)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (Flush) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign SampleValid = ~fifo_empty;
  assign Overflow    = overflow_q;
  assign DropCnt     = drop_cnt_q;
  assign DbgState    = state_q;

endmodule

// File: tb/tb_adc_sample_ingest.sv
// Directed bench for adc_sample_ingest: latency, arming, overflow/flush, full push+pop, reset, DC removal.
module tb_adc_sample_ingest;

  localparam int DEPTH    = 16;
  localparam int DC_SHIFT = 6;
`ifdef DC_REMOVE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Enable = 1'b0;
  logic        Flush = 1'b0;
  logic        AdcClk = 1'b1;
  logic [7:0]  AdcData = 8'h00;
  logic        SampleReady = 1'b0;
  logic [7:0]  SampleOut;
  logic        SampleValid;
  logic        Overflow;
  logic [15:0] DropCnt;
  logic [4:0]  Level;
  logic [1:0]  DbgState;

  adc_sample_ingest #(
    .FIFO_DEPTH (DEPTH),
    .DC_SHIFT   (DC_SHIFT),
    .DROP_CNT_W (16)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Enable      (Enable),
    .Flush       (Flush),
    .AdcClk      (AdcClk),
    .AdcData     (AdcData),
    .SampleOut   (SampleOut),
    .SampleValid (SampleValid),
    .SampleReady (SampleReady),
    .Overflow    (Overflow),
    .DropCnt     (DropCnt),
    .Level       (Level),
    .DbgState    (DbgState)
  );

  // Clock / reset
  always #5 Clk = ~Clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  int         dc_acc  = 0;
  int         t5_n    = 0;
  int         t5_prev = 0;
  int         t5_last = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Expected written sample: data - 128, optionally through the DC tracker.
  function automatic logic [7:0] model(input logic [7:0] d);
    int s;
    int e;
    s = int'(d) - 128;
    e = s;
`ifdef DC_REMOVE_EN
    e = s - (dc_acc >>> DC_SHIFT);
    dc_acc = dc_acc + e;
    if (e > 127)  e = 127;
    if (e < -128) e = -128;
`endif
    return 8'(e);
  endfunction

  // One AdcClk period of 20 Clk: rise with new data, fall at mid-period.
  task automatic adc_period(input logic [7:0] d, input bit capt, input bit keep);
    logic [7:0] m;
    AdcClk  = 1'b1;
    AdcData = d;
    ticks(10);
    AdcClk = 1'b0;
    ticks(10);
    if (capt) begin
      m = model(d);
      if (keep) exp_q.push_back(m);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    SampleReady = 1'b1;
    while (exp_q.size() > 0 && n < 400) begin
      if (SampleValid) check("drain_data", {24'h0, SampleOut}, {24'h0, exp_q.pop_front()});
      tick();
      n++;
    end
    SampleReady = 1'b0;
    check("drain_done", exp_q.size(), 0);
    check("drain_level", {27'h0, Level}, 0);
  endtask

  task automatic flush_pulse();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    dc_acc = 0;
    exp_q.delete();
  endtask

  task automatic t5_observe();
    int v;
    tick();
    if (SampleValid) begin
      v = int'($signed(SampleOut));
      if (t5_n == 0) check("t5_first", v, 32);
      else           check("t5_mono", {31'h0, (v <= t5_prev)}, 1);
      t5_prev = v;
      t5_last = v;
      t5_n++;
    end
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    // Reset values
    ticks(3);
    check("rst_out",   {24'h0, SampleOut}, 0);
    check("rst_valid", {31'h0, SampleValid}, 0);
    check("rst_ovf",   {31'h0, Overflow}, 0);
    check("rst_drop",  {16'h0, DropCnt}, 0);
    check("rst_level", {27'h0, Level}, 0);
    check("rst_state", {30'h0, DbgState}, 0);
    Reset_n = 1'b1;
    tick();

    // 1: basic conversion and latency
    AdcClk = 1'b0;
    Enable = 1'b1;
    ticks(5);
    check("t1_arm", {30'h0, DbgState}, 1);
    AdcClk  = 1'b1;
    AdcData = 8'h80;
    ticks(10);
    check("t1_run", {30'h0, DbgState}, 2);
    AdcClk = 1'b0;
    ticks(LAT - 1);
    check("t1_lat_early", {31'h0, SampleValid}, 0);
    tick();
    check("t1_lat", {31'h0, SampleValid}, 1);
    ticks(10 - LAT);
    exp_q.push_back(model(8'h80));
    adc_period(8'hFF, 1, 1);
    adc_period(8'h00, 1, 1);
    check("t1_level", {27'h0, Level}, 3);
`ifndef DC_REMOVE_EN
    check("t1_hand0", {24'h0, exp_q[0]}, 32'h00);
    check("t1_hand1", {24'h0, exp_q[1]}, 32'h7F);
    check("t1_hand2", {24'h0, exp_q[2]}, 32'h80);
`endif
    drain();

    // 2: enable mid-period must wait for a rise
    Enable  = 1'b0;
    AdcClk  = 1'b1;
    AdcData = 8'h11;
    ticks(5);
    check("t2_idle", {30'h0, DbgState}, 0);
    Enable = 1'b1;
    ticks(5);
    AdcClk = 1'b0;
    ticks(10);
    check("t2_no_partial", {27'h0, Level}, 0);
    adc_period(8'h33, 1, 1);
    check("t2_level", {27'h0, Level}, 1);
    drain();
    Enable = 1'b0;
    tick();
    Enable = 1'b1;
    ticks(4);
    check("t2_low_nocap", {27'h0, Level}, 0);
    adc_period(8'h44, 1, 1);
    drain();

    // 3: overflow with three drops, then flush
    for (int i = 0; i < DEPTH + 3; i++) adc_period(8'(i * 13 + 5), 1, i < DEPTH);
    check("t3_level", {27'h0, Level}, DEPTH);
    check("t3_ovf",   {31'h0, Overflow}, 1);
    check("t3_drop",  {16'h0, DropCnt}, 3);
    drain();
    check("t3_ovf_sticky", {31'h0, Overflow}, 1);
    adc_period(8'h21, 1, 1);
    adc_period(8'h22, 1, 1);
    flush_pulse();
    check("t3_fl_level", {27'h0, Level}, 0);
    check("t3_fl_valid", {31'h0, SampleValid}, 0);
    check("t3_fl_ovf",   {31'h0, Overflow}, 0);
    check("t3_fl_drop",  {16'h0, DropCnt}, 0);
    check("t3_fl_state", {30'h0, DbgState}, 2);

    // 4: full FIFO, push coinciding with pop
    for (int i = 0; i < DEPTH; i++) adc_period(8'(8'hF0 - i * 7), 1, 1);
    check("t4_full", {27'h0, Level}, DEPTH);
    AdcClk  = 1'b1;
    AdcData = 8'hC3;
    ticks(10);
    AdcClk = 1'b0;
    ticks(LAT - 1);
    check("t4_head", {24'h0, SampleOut}, {24'h0, exp_q.pop_front()});
    SampleReady = 1'b1;
    tick();
    SampleReady = 1'b0;
    exp_q.push_back(model(8'hC3));
    ticks(10 - LAT);
    check("t4_level", {27'h0, Level}, DEPTH);
    check("t4_drop",  {16'h0, DropCnt}, 0);
    check("t4_ovf",   {31'h0, Overflow}, 0);
    drain();

    // 6: asynchronous reset mid-stream with FIFO half full
    for (int i = 0; i < DEPTH / 2; i++) adc_period(8'(8'h40 + i), 1, 1);
    check("t6_half", {27'h0, Level}, DEPTH / 2);
    #3;
    Reset_n = 1'b0;
    #1;
    check("t6_out",   {24'h0, SampleOut}, 0);
    check("t6_valid", {31'h0, SampleValid}, 0);
    check("t6_level", {27'h0, Level}, 0);
    check("t6_state", {30'h0, DbgState}, 0);
    exp_q.delete();
    dc_acc = 0;
    ticks(2);
    Reset_n = 1'b1;
    ticks(3);
    adc_period(8'h5A, 1, 1);
    adc_period(8'hA5, 1, 1);
    drain();

`ifdef DC_REMOVE_EN
    // 5: DC removal on a constant +32 input
    flush_pulse();
    SampleReady = 1'b1;
    for (int i = 0; i < (1 << DC_SHIFT) * 8; i++) begin
      AdcClk  = 1'b1;
      AdcData = 8'hA0;
      t5_observe();
      t5_observe();
      AdcClk = 1'b0;
      t5_observe();
      t5_observe();
    end
    for (int i = 0; i < 6; i++) t5_observe();
    SampleReady = 1'b0;
    check("t5_count", t5_n, (1 << DC_SHIFT) * 8);
    check("t5_final", {31'h0, (t5_last <= 1 && t5_last >= -1)}, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
